// File: rtl/riscv_pkg.sv
// Shared definitions for the writeback-side register file and its scoreboard.
package riscv_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int REG_ADDR_W    = $clog2(NREGS_DEFAULT);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Register 0 is hardwired; only non-zero indices hold state or pend.
    function automatic logic addr_is_live(input reg_addr_t addr);
        return (addr != '0);
    endfunction

endpackage : riscv_pkg

// File: rtl/reg_scoreboard.sv
// Per-register pending scoreboard for long-latency results and the Decode
// stall compare. A writeback that retires a long result releases its
// dependents in the same cycle; the data reaches them through the read bypass.
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREGS)-1:0] rs1_addr,
    input  logic [$clog2(NREGS)-1:0] rs2_addr,
    input  logic [$clog2(NREGS)-1:0] rd_dec,
    input  logic                     long_issue,
    input  logic                     reg_write,
    input  logic [$clog2(NREGS)-1:0] rd_wb,
    input  logic                     long_done,
    output logic                     stall,
    output logic [NREGS-1:0]         pending_mask
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [NREGS-1:0] clr_vec_s;
    logic [NREGS-1:0] set_vec_s;
    logic [NREGS-1:0] live_s;
    logic             stall_s;

    // Decode the retiring long writeback into a one-hot clear vector.
    always_comb begin
        clr_vec_s = '0;
        if (reg_write && long_done && (rd_wb != '0)) begin
            clr_vec_s[rd_wb] = 1'b1;
        end else begin
            clr_vec_s = '0;
        end
    end

    // Pending bits still in force this cycle, after same-cycle release.
    always_comb begin
        live_s = pend_q & ~clr_vec_s;
    end

    // Stall on any live pending source, or on a live pending destination (WAW).
    always_comb begin
        stall_s = 1'b0;
        if ((rs1_addr != '0) && live_s[rs1_addr]) begin
            stall_s = 1'b1;
        end else if ((rs2_addr != '0) && live_s[rs2_addr]) begin
            stall_s = 1'b1;
        end else if ((rd_dec != '0) && live_s[rd_dec]) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // A non-stalled long issue claims its destination register.
    always_comb begin
        set_vec_s = '0;
        if (long_issue && !stall_s && (rd_dec != '0)) begin
            set_vec_s[rd_dec] = 1'b1;
        end else begin
            set_vec_s = '0;
        end
    end

    // Next pending state: clear first, then set, so a new issuer wins a tie.
    always_comb begin
        pend_d    = (pend_q & ~clr_vec_s) | set_vec_s;
        pend_d[0] = 1'b0;
    end

    // Pending register; reset drops every outstanding claim.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign stall        = stall_s;
    assign pending_mask = pend_q;

endmodule : reg_scoreboard

// File: rtl/reg_file_wb.sv
// Writeback-side register file: two combinational read ports with a
// same-cycle write-to-read bypass, plus the long-latency pending scoreboard.
module reg_file_wb
    import riscv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREGS)-1:0] Rs1D,
    input  logic [$clog2(NREGS)-1:0] Rs2D,
    output logic [WIDTH-1:0]         RD1D,
    output logic [WIDTH-1:0]         RD2D,
    input  logic [$clog2(NREGS)-1:0] RdD,
    input  logic                     LongIssueD,
    input  logic                     RegWriteW,
    input  logic [$clog2(NREGS)-1:0] RdW,
    input  logic [WIDTH-1:0]         ResultW,
    input  logic                     LongDoneW,
    output logic                     StallD,
    output logic [NREGS-1:0]         PendingMask
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic             wr_en_s;
    logic [WIDTH-1:0] rd1_s;
    logic [WIDTH-1:0] rd2_s;

    // Writes to register 0 are dropped.
    always_comb begin
        wr_en_s = 1'b0;
        if (RegWriteW && (RdW != '0)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Next array contents: only the addressed register changes.
    always_comb begin
        regs_d = regs_q;
        if (wr_en_s) begin
            regs_d[RdW] = ResultW;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register array; reset clears every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port 1: zero register, then bypass of this cycle's write, then array.
    always_comb begin
        rd1_s = '0;
        if (Rs1D == '0) begin
            rd1_s = '0;
        end else if (wr_en_s && (RdW == Rs1D)) begin
            rd1_s = ResultW;
        end else begin
            rd1_s = regs_q[Rs1D];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd2_s = '0;
        if (Rs2D == '0) begin
            rd2_s = '0;
        end else if (wr_en_s && (RdW == Rs2D)) begin
            rd2_s = ResultW;
        end else begin
            rd2_s = regs_q[Rs2D];
        end
    end

    assign RD1D = rd1_s;
    assign RD2D = rd2_s;

    reg_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs1_addr     (Rs1D),
        .rs2_addr     (Rs2D),
        .rd_dec       (RdD),
        .long_issue   (LongIssueD),
        .reg_write    (RegWriteW),
        .rd_wb        (RdW),
        .long_done    (LongDoneW),
        .stall        (StallD),
        .pending_mask (PendingMask)
    );

endmodule : reg_file_wb
